state_mux_seq: RTL and testbench
================================

Name: state_mux_seq

Overview:
- Parametrised, registered successor to the calculator's display-value selector.
- Picks one of NCH W-bit data channels for the 7-segment driver in one of four modes:
  - state-following, with a parameter-defined state-to-channel map;
  - auto-scan, with a dwell counter;
  - hold (freeze);
  - blank.
- Sits between the control FSM / datapath registers and the display driver.
- Registered output; a change strobe lets the display refresh only on new data.

Parameters:
- W, 16, width of each channel and of val.
- NCH, 4, number of input channels (>=2).
- SW, 3, width of the state input.
- CW, 2, channel index width, equal to clog2(NCH).
- STATE_MAP, 16'h0100, packed table of 2**SW entries of CW bits; entry i at [i*CW +: CW] is the channel shown in state i. Default maps state 4 to ch1 and all other states to ch0.
- DWELL, 100, clock cycles each channel is shown in SCAN mode (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- state  input  SW  current control-FSM state.
- mode  input  2  00 FOLLOW, 01 SCAN, 10 HOLD, 11 BLANK.
- ch_data  input  NCH*W  packed channels; channel k at [k*W +: W]. Narrower sources are zero-extended by the integrator.
- val  output  W  registered selected value.
- ch_idx  output  CW  channel currently driving val.
- blank  output  1  high while in BLANK mode.
- val_changed  output  1  one-cycle pulse, high in the cycle val takes a new, different value.

Behaviour:
- Reset (reset_n low, asynchronous): val=0, ch_idx=0, blank=0, val_changed=0, dwell counter=0, previous-mode register=FOLLOW. All outputs stay registered at these values until the first rising edge after reset_n rises.
- Latency: 1 cycle. Inputs sampled at edge n appear on outputs after edge n.
- FOLLOW:
  - ch_idx <= STATE_MAP[state].
  - If the map entry >= NCH, ch_idx <= 0 (default channel).
  - val <= selected channel data.
  - Dwell counter is held at 0.
- SCAN:
  - Dwell counter counts 0..DWELL-1.
  - On terminal count: counter <= 0, ch_idx <= ch_idx+1, wrapping NCH-1 -> 0.
  - val <= ch_data of the ch_idx in effect after the update. Live data of the shown channel is tracked every cycle.
  - Entering SCAN from any other mode: counter <= 0, ch_idx <= 0 on the entry edge.
  - A mode change on a terminal-count edge takes priority: no advance.
  - DWELL=1 advances every cycle.
- HOLD: val, ch_idx and counter keep their values. Input changes are ignored.
- BLANK:
  - val <= 0, blank <= 1.
  - ch_idx holds; counter <= 0.
  - Leaving BLANK clears blank on the same edge the new mode takes effect.
- val_changed:
  - <= (next val != current val), evaluated on every edge, all modes.
  - Never asserted in HOLD.
  - Asserted on entry to BLANK only if val was nonzero.
- Widths: all channel and val arithmetic is exactly W bits. No truncation or sign extension inside the block. ch_idx increment wraps modulo NCH, not modulo 2**CW.
- Reset asserted mid-scan or mid-hold forces the reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset/FOLLOW: reset_n=0 with ch_data nonzero -> val=0, ch_idx=0, blank=0. Release, then mode=00, state=4, ch1=16'h0013 -> after 1 edge val=16'h0013, ch_idx=1, val_changed pulses 1 cycle.
- Map default: state=0/2/7 with ch0=16'hBEEF -> val=16'hBEEF, ch_idx=0. Changing ch0 to 16'h1234 in state 0 -> val follows after 1 cycle with a val_changed pulse.
- SCAN wrap:
  - Setup: DWELL=3, NCH=4, channels 1,2,3,4, mode=01.
  - Expected: ch_idx sequence 0,1,2,3,0, each held 3 cycles; val=1,2,3,4,1; val_changed pulses at each advance.
  - Switching to FOLLOW on a terminal-count edge -> no advance, FOLLOW selection used.
- HOLD: from val=16'h0013, mode=10, then change ch_data and state over 10 cycles -> val, ch_idx constant, val_changed never asserted.
- BLANK: mode=11 with val=16'h0013 -> next edge val=0, blank=1, val_changed=1 for one cycle. Return to FOLLOW -> blank=0, val restored one edge later.
- Async reset mid-scan: pulse reset_n low between clock edges during SCAN -> outputs reach reset values before the next edge. Scan restarts from ch 0 with a full DWELL period after release.

Source files
------------

// File: rtl/state_mux_seq_if.sv
// Channel/selection bundle between the control-side sources and the display-value selector.
// master drives the selection inputs and channel data; slave is the selector itself.
interface state_mux_seq_if #(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int SW  = 3,
  parameter int CW  = 2
);
  logic [SW-1:0]    state;
  logic [1:0]       mode;
  logic [NCH*W-1:0] ch_data;
  logic [W-1:0]     val;
  logic [CW-1:0]    ch_idx;
  logic             blank;
  logic             val_changed;

  modport master (
    output state, mode, ch_data,
    input  val, ch_idx, blank, val_changed
  );

  modport slave (
    input  state, mode, ch_data,
    output val, ch_idx, blank, val_changed
  );
endinterface

// File: rtl/state_mux_seq.sv
// Registered display-value selector: follows the FSM state, auto-scans, holds or blanks,
// and pulses val_changed whenever the registered value actually changes.
module state_mux_seq #(
  parameter int                   W         = 16,
  parameter int                   NCH       = 4,
  parameter int                   SW        = 3,
  parameter int                   CW        = 2,
  parameter logic [CW*(2**SW)-1:0] STATE_MAP = 16'h0100,
  parameter int                   DWELL     = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  state_mux_seq_if.slave   bus
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    MODE_FOLLOW = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_t;

  logic [W-1:0]  ch_arr  [NCH];
  logic [CW-1:0] map_arr [2**SW];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_arr[gi] = bus.ch_data[gi*W +: W];
    end
    // Out-of-range map entries fall back to channel 0 at elaboration time.
    for (genvar gi = 0; gi < 2**SW; gi++) begin : g_map
      assign map_arr[gi] = (int'(STATE_MAP[gi*CW +: CW]) < NCH) ? STATE_MAP[gi*CW +: CW] : '0;
    end
  endgenerate

  mode_t          mode_cur;
  mode_t          prev_mode_reg;
  logic [W-1:0]   val_reg,   val_next;
  logic [CW-1:0]  idx_reg,   idx_next;
  logic [DCW-1:0] cnt_reg,   cnt_next;
  logic           blank_reg, blank_next;
  logic           chg_reg,   chg_next;

  assign mode_cur = mode_t'(bus.mode);

  always_comb begin
    val_next = val_reg;
    idx_next = idx_reg;
    cnt_next = cnt_reg;
    case (mode_cur)
      MODE_FOLLOW: begin
        idx_next = map_arr[bus.state];
        cnt_next = '0;
        val_next = ch_arr[idx_next];
      end
      MODE_SCAN: begin
        if (prev_mode_reg != MODE_SCAN) begin
          idx_next = '0;
          cnt_next = '0;
        end else if (cnt_reg == DCW'(DWELL - 1)) begin
          cnt_next = '0;
          idx_next = (idx_reg == CW'(NCH - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
        val_next = ch_arr[idx_next];
      end
      MODE_BLANK: begin
        val_next = '0;
        cnt_next = '0;
      end
      default: ;
    endcase
    blank_next = (mode_cur == MODE_BLANK);
    chg_next   = (val_next != val_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_reg       <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      blank_reg     <= 1'b0;
      chg_reg       <= 1'b0;
      prev_mode_reg <= MODE_FOLLOW;
    end else begin
      val_reg       <= val_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      blank_reg     <= blank_next;
      chg_reg       <= chg_next;
      prev_mode_reg <= mode_cur;
    end
  end

  assign bus.val         = val_reg;
  assign bus.ch_idx      = idx_reg;
  assign bus.blank       = blank_reg;
  assign bus.val_changed = chg_reg;

endmodule

// File: tb/tb_state_mux_seq.sv
// Randomised and directed checks of state_mux_seq against a cycle-level behavioural model,
// on two instances: default (NCH=4, DWELL=3) and narrow (NCH=3, DWELL=1, map with invalid entries).
module tb_state_mux_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  state;
  logic [1:0]  mode;
  logic [63:0] ch_data;

  int n_checks = 0;
  int n_pass   = 0;

  state_mux_seq_if #(.W(16), .NCH(4), .SW(3), .CW(2)) bus_a ();
  state_mux_seq_if #(.W(16), .NCH(3), .SW(3), .CW(2)) bus_b ();

  assign bus_a.state   = state;
  assign bus_a.mode    = mode;
  assign bus_a.ch_data = ch_data;
  assign bus_b.state   = state;
  assign bus_b.mode    = mode;
  assign bus_b.ch_data = ch_data[47:0];

  state_mux_seq #(.W(16), .NCH(4), .SW(3), .CW(2), .STATE_MAP(16'h0100), .DWELL(3)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  state_mux_seq #(.W(16), .NCH(3), .SW(3), .CW(2), .STATE_MAP(16'hE4E7), .DWELL(1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  // Reference model: one entry per instance.
  int          nch_p   [2] = '{4, 3};
  int          dwell_p [2] = '{3, 1};
  logic [15:0] map_p   [2] = '{16'h0100, 16'hE4E7};
  int m_val [2], m_idx [2], m_blank [2], m_chg [2], m_t [2], m_last [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int chan(input int k);
    return int'(ch_data[k*16 +: 16]);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_val[u] = 0; m_idx[u] = 0; m_blank[u] = 0; m_chg[u] = 0; m_t[u] = 0; m_last[u] = 0;
    end
  endtask

  task automatic model_step();
    int nv;
    int ix;
    int s;
    s = int'(state);
    for (int u = 0; u < 2; u++) begin
      nv = m_val[u];
      ix = m_idx[u];
      case (int'(mode))
        0: begin
          ix = int'((map_p[u] >> (s * 2)) & 16'h3);
          if (ix >= nch_p[u]) ix = 0;
          nv = chan(ix);
        end
        1: begin
          // Elapsed edges since entering SCAN determine the shown channel.
          if (m_last[u] != 1) m_t[u] = 0;
          else m_t[u] = m_t[u] + 1;
          ix = (m_t[u] / dwell_p[u]) % nch_p[u];
          nv = chan(ix);
        end
        3: nv = 0;
        default: ;
      endcase
      m_chg[u]   = (nv != m_val[u]) ? 1 : 0;
      m_val[u]   = nv;
      m_idx[u]   = ix;
      m_blank[u] = (mode == 2'b11) ? 1 : 0;
      m_last[u]  = int'(mode);
    end
  endtask

  task automatic chk_all();
    chk("A.val",     32'(bus_a.val),         m_val[0]);
    chk("A.ch_idx",  32'(bus_a.ch_idx),      m_idx[0]);
    chk("A.blank",   32'(bus_a.blank),       m_blank[0]);
    chk("A.changed", 32'(bus_a.val_changed), m_chg[0]);
    chk("B.val",     32'(bus_b.val),         m_val[1]);
    chk("B.ch_idx",  32'(bus_b.ch_idx),      m_idx[1]);
    chk("B.blank",   32'(bus_b.blank),       m_blank[1]);
    chk("B.changed", 32'(bus_b.val_changed), m_chg[1]);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    chk_all();
    $display("t=%0t mode=%0d state=%0d A:val=%h idx=%0d blk=%0b chg=%0b B:val=%h idx=%0d",
             $time, mode, state, bus_a.val, bus_a.ch_idx, bus_a.blank, bus_a.val_changed,
             bus_b.val, bus_b.ch_idx);
  endtask

  int scan_exp [15] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};

  initial begin
    reset_n = 1'b0;
    state   = 3'd4;
    mode    = 2'b00;
    ch_data = '1;
    model_reset();
    #2;
    chk("rst.val",   32'(bus_a.val), 0);
    chk("rst.idx",   32'(bus_a.ch_idx), 0);
    chk("rst.blank", 32'(bus_a.blank), 0);
    chk_all();
    step();
    step();
    #3 reset_n = 1'b1;

    // FOLLOW with mapped state 4 -> channel 1
    ch_data = 64'h0000_0000_0013_0000;
    step();
    chk("follow.val", 32'(bus_a.val), 32'h0013);
    chk("follow.idx", 32'(bus_a.ch_idx), 1);
    chk("follow.chg", 32'(bus_a.val_changed), 1);
    step();
    chk("follow.chg_drop", 32'(bus_a.val_changed), 0);

    // Default map entries route to channel 0
    ch_data = 64'h0000_0000_0013_BEEF;
    state = 3'd0; step();
    chk("map0.val", 32'(bus_a.val), 32'hBEEF);
    chk("map0.idx", 32'(bus_a.ch_idx), 0);
    state = 3'd2; step();
    chk("map2.val", 32'(bus_a.val), 32'hBEEF);
    state = 3'd7; step();
    chk("map7.val", 32'(bus_a.val), 32'hBEEF);
    chk("map7.chg", 32'(bus_a.val_changed), 0);
    state = 3'd0; ch_data[15:0] = 16'h1234; step();
    chk("map0.track", 32'(bus_a.val), 32'h1234);
    chk("map0.trk_chg", 32'(bus_a.val_changed), 1);

    // SCAN wrap with DWELL=3
    ch_data = {16'd4, 16'd3, 16'd2, 16'd1};
    mode = 2'b01;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("scan.idx", 32'(bus_a.ch_idx), scan_exp[i]);
      chk("scan.val", 32'(bus_a.val), scan_exp[i] + 1);
      chk("scan.chg", 32'(bus_a.val_changed), (i % 3 == 0) ? 1 : 0);
    end
    // Mode change on a terminal-count edge: FOLLOW wins, no advance
    mode = 2'b00; state = 3'd0; step();
    chk("scan2follow.idx", 32'(bus_a.ch_idx), 0);
    chk("scan2follow.val", 32'(bus_a.val), 1);
    chk("scan2follow.chg", 32'(bus_a.val_changed), 0);

    // HOLD freezes everything
    state = 3'd4; ch_data = 64'h0000_0000_0013_0000; step();
    mode = 2'b10;
    for (int i = 0; i < 10; i++) begin
      ch_data = {$urandom, $urandom};
      state = 3'($urandom);
      step();
      chk("hold.val", 32'(bus_a.val), 32'h0013);
      chk("hold.idx", 32'(bus_a.ch_idx), 1);
      chk("hold.chg", 32'(bus_a.val_changed), 0);
    end

    // BLANK and return
    mode = 2'b11; step();
    chk("blank.val", 32'(bus_a.val), 0);
    chk("blank.blank", 32'(bus_a.blank), 1);
    chk("blank.chg", 32'(bus_a.val_changed), 1);
    step();
    chk("blank.chg2", 32'(bus_a.val_changed), 0);
    ch_data = 64'h0000_0000_0013_0000; state = 3'd4; mode = 2'b00; step();
    chk("unblank.blank", 32'(bus_a.blank), 0);
    chk("unblank.val", 32'(bus_a.val), 32'h0013);

    // Asynchronous reset in the middle of a scan
    ch_data = {16'd8, 16'd7, 16'd6, 16'd5};
    mode = 2'b01;
    for (int i = 0; i < 4; i++) step();
    chk("prerst.idx", 32'(bus_a.ch_idx), 1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst.val", 32'(bus_a.val), 0);
    chk("arst.idx", 32'(bus_a.ch_idx), 0);
    chk_all();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rescan.idx", 32'(bus_a.ch_idx), (i < 3) ? 0 : 1);
      chk("rescan.val", 32'(bus_a.val), (i < 3) ? 5 : 6);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
      state = 3'($urandom);
      if ($urandom_range(0, 7) == 0) ch_data = '0;
      else if ($urandom_range(0, 3) != 0) ch_data = {$urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
